// File: rtl/oam_dma.sv
// oam_dma: NES sprite DMA engine sitting between the T65 CPU and databus.
// Optional OAM_DMA_ODD_ALIGN_EN adds the odd-cycle ALIGN state (parity tracking).
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_PORT = 16'h2004
) (
    input  logic        Clk,
    input  logic        Res_n,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_WR,
    input  logic [7:0]  BUS_DI,
    output logic        CPU_RDY,
    output logic [15:0] BUS_ADDR,
    output logic        BUS_WR,
    output logic [7:0]  BUS_DO,
    output logic        DMA_ACTIVE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_buf;
    logic        trigger;
    logic        last_byte;

    assign CPU_RDY    = (state == IDLE);
    assign DMA_ACTIVE = (state != IDLE);
    assign trigger    = CPU_RDY && !CPU_WR && (CPU_ADDR == DMA_REG);
    assign last_byte  = (idx == 8'hFF);

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic parity;

    // Free-running cycle parity used to decide whether ALIGN is needed
    always_ff @(posedge Clk) begin
        if (!Res_n) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Page latch, byte index and read-data buffer
    always_ff @(posedge Clk) begin
        if (!Res_n) begin
            page     <= 8'h00;
            idx      <= 8'h00;
            data_buf <= 8'h00;
        end else begin
            if (trigger) begin
                page <= CPU_DO;
                idx  <= 8'h00;
            end
            if (state == READ) begin
                data_buf <= BUS_DI;
            end
            if (state == WRITE && !last_byte) begin
                idx <= idx + 8'h01;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                state_nxt = parity ? ALIGN : READ;
`else
                state_nxt = READ;
`endif
            end
            ALIGN: state_nxt = READ;
            READ:  state_nxt = WRITE;
            WRITE: state_nxt = last_byte ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux: CPU pass-through unless the engine owns the cycle
    always_comb begin
        BUS_ADDR = CPU_ADDR;
        BUS_WR   = CPU_WR;
        BUS_DO   = CPU_DO;
        unique case (state)
            IDLE: begin
                BUS_WR = CPU_WR;
            end
            HALT, ALIGN: begin
                BUS_WR = 1'b1;
            end
            READ: begin
                BUS_ADDR = {page, idx};
                BUS_WR   = 1'b1;
            end
            WRITE: begin
                BUS_ADDR = OAM_PORT;
                BUS_WR   = 1'b0;
                BUS_DO   = data_buf;
            end
            default: begin
                BUS_WR = CPU_WR;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for the oam_dma sprite DMA engine.
// Bus memory is a flat 64K array returning read data combinationally.
module tb_oam_dma;

    logic        Clk;
    logic        Res_n;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DO;
    logic        CPU_WR;
    logic [7:0]  BUS_DI;
    logic        CPU_RDY;
    logic [15:0] BUS_ADDR;
    logic        BUS_WR;
    logic [7:0]  BUS_DO;
    logic        DMA_ACTIVE;

    oam_dma dut (
        .Clk       (Clk),
        .Res_n     (Res_n),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_DO    (CPU_DO),
        .CPU_WR    (CPU_WR),
        .BUS_DI    (BUS_DI),
        .CPU_RDY   (CPU_RDY),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_WR    (BUS_WR),
        .BUS_DO    (BUS_DO),
        .DMA_ACTIVE(DMA_ACTIVE)
    );

    logic [7:0] mem [0:65535];
    assign BUS_DI = mem[BUS_ADDR];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference cycle parity: cleared by reset, toggles every edge
    logic tb_par = 1'b0;
    always @(posedge Clk) tb_par <= !Res_n ? 1'b0 : ~tb_par;

    int          stall_cnt = 0;
    int          wcnt      = 0;
    int          bad_wr    = 0;
    int          bb_err    = 0;
    logic        prev_wr   = 1'b0;
    logic [15:0] last_rd   = 16'h0000;
    logic [7:0]  wdata [0:255];

    // Bus observer, sampled mid-cycle
    always @(negedge Clk) begin
        if (!CPU_RDY) stall_cnt++;
        if (DMA_ACTIVE && !BUS_WR) begin
            if (BUS_ADDR != 16'h2004) bad_wr++;
            if (wcnt < 256) wdata[wcnt] = BUS_DO;
            wcnt++;
            if (prev_wr) bb_err++;
        end
        if (DMA_ACTIVE && BUS_WR) last_rd = BUS_ADDR;
        prev_wr = DMA_ACTIVE && !BUS_WR;
    end

    task automatic do_dma(input logic [7:0] pg, input logic want_par,
                          output int stall, output logic tmo);
        @(posedge Clk); #1;
        while (tb_par == want_par) begin
            @(posedge Clk); #1;
        end
        stall_cnt = 0;
        wcnt      = 0;
        bad_wr    = 0;
        bb_err    = 0;
        CPU_ADDR  = 16'h4014;
        CPU_DO    = pg;
        CPU_WR    = 1'b0;
        @(posedge Clk); #1;
        CPU_WR = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            if (CPU_RDY) begin
                tmo = 1'b0;
                break;
            end
        end
        stall = stall_cnt;
    endtask

    task automatic test_reset;
        Res_n    = 1'b0;
        CPU_ADDR = 16'h8000;
        CPU_DO   = 8'h00;
        CPU_WR   = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Res_n = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (BUS_ADDR !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_addr got=%h exp=8000", BUS_ADDR);
        end
        n_checks++;
        if (BUS_WR !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wr got=%b exp=1", BUS_WR);
        end
        n_checks++;
        if (CPU_RDY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy got=%b exp=1", CPU_RDY);
        end
        n_checks++;
        if (DMA_ACTIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active got=%b exp=0", DMA_ACTIVE);
        end
    endtask

    task automatic test_copy_even;
        int   st;
        logic to;
        do_dma(8'h02, 1'b0, st, to);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL even_timeout got=%b exp=0", to);
        end
        n_checks++;
        if (st != 513) begin
            n_fail++;
            $display("FAIL even_stall got=%0d exp=513", st);
        end
        n_checks++;
        if (wcnt != 256 || bad_wr != 0) begin
            n_fail++;
            $display("FAIL even_writes got=%0d bad=%0d exp=256 bad=0",
                     wcnt, bad_wr);
        end
        n_checks++;
        if (bb_err != 0) begin
            n_fail++;
            $display("FAIL even_b2b got=%0d exp=0", bb_err);
        end
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (wdata[i] !== (8'(i) ^ 8'hA5)) begin
                n_fail++;
                $display("FAIL even_data[%0d] got=%h exp=%h",
                         i, wdata[i], 8'(i) ^ 8'hA5);
            end
        end
    endtask

    task automatic test_copy_odd;
        int   st;
        logic to;
        int   exp_st;
`ifdef OAM_DMA_ODD_ALIGN_EN
        exp_st = 514;
`else
        exp_st = 513;
`endif
        do_dma(8'h02, 1'b1, st, to);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_timeout got=%b exp=0", to);
        end
        n_checks++;
        if (st != exp_st) begin
            n_fail++;
            $display("FAIL odd_stall got=%0d exp=%0d", st, exp_st);
        end
        n_checks++;
        if (wcnt != 256 || bb_err != 0) begin
            n_fail++;
            $display("FAIL odd_writes got=%0d b2b=%0d exp=256 b2b=0",
                     wcnt, bb_err);
        end
        n_checks++;
        if (wdata[0] !== 8'hA5 || wdata[255] !== 8'h5A) begin
            n_fail++;
            $display("FAIL odd_data got=%h,%h exp=a5,5a",
                     wdata[0], wdata[255]);
        end
    endtask

    task automatic test_page_ff;
        int   st;
        logic to;
        do_dma(8'hFF, 1'b0, st, to);
        n_checks++;
        if (to !== 1'b0 || st != 513) begin
            n_fail++;
            $display("FAIL ff_stall got=%0d to=%b exp=513 to=0", st, to);
        end
        n_checks++;
        if (last_rd !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL ff_last_rd got=%h exp=ffff", last_rd);
        end
        n_checks++;
        if (wcnt != 256) begin
            n_fail++;
            $display("FAIL ff_writes got=%0d exp=256", wcnt);
        end
        n_checks++;
        if (wdata[0] !== 8'h3C || wdata[255] !== 8'hC3) begin
            n_fail++;
            $display("FAIL ff_data got=%h,%h exp=3c,c3",
                     wdata[0], wdata[255]);
        end
        @(negedge Clk);
        n_checks++;
        if (DMA_ACTIVE !== 1'b0 || CPU_RDY !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_idle got act=%b rdy=%b exp act=0 rdy=1",
                     DMA_ACTIVE, CPU_RDY);
        end
    endtask

    task automatic test_reset_abort;
        logic found;
        int   st;
        logic to;
        @(posedge Clk); #1;
        CPU_ADDR = 16'h4014;
        CPU_DO   = 8'h02;
        CPU_WR   = 1'b0;
        @(posedge Clk); #1;
        CPU_WR = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (DMA_ACTIVE && BUS_WR && BUS_ADDR == 16'h0240) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_reach got=0 exp=1");
        end
        Res_n = 1'b0;
        @(posedge Clk); #1;
        Res_n = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got rdy=%b act=%b exp rdy=1 act=0",
                     CPU_RDY, DMA_ACTIVE);
        end
        n_checks++;
        if (BUS_ADDR !== 16'h4014 || BUS_WR !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pass got=%h/%b exp=4014/1",
                     BUS_ADDR, BUS_WR);
        end
        do_dma(8'h02, 1'b0, st, to);
        n_checks++;
        if (to !== 1'b0 || st != 513 || wcnt != 256) begin
            n_fail++;
            $display("FAIL restart got st=%0d w=%0d exp st=513 w=256",
                     st, wcnt);
        end
        n_checks++;
        if (wdata[0] !== 8'hA5 || wdata[64] !== 8'hE5) begin
            n_fail++;
            $display("FAIL restart_data got=%h,%h exp=a5,e5",
                     wdata[0], wdata[64]);
        end
    endtask

    task automatic test_non_trigger;
        logic [15:0] addrs [0:1];
        addrs[0] = 16'h4013;
        addrs[1] = 16'h4015;
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk); #1;
            CPU_ADDR = addrs[k];
            CPU_DO   = 8'h02;
            CPU_WR   = 1'b0;
            @(negedge Clk);
            n_checks++;
            if (BUS_ADDR !== addrs[k] || BUS_WR !== 1'b0
                || BUS_DO !== 8'h02) begin
                n_fail++;
                $display("FAIL nt_pass got=%h/%b/%h exp=%h/0/02",
                         BUS_ADDR, BUS_WR, BUS_DO, addrs[k]);
            end
            @(posedge Clk); #1;
            CPU_WR   = 1'b1;
            CPU_ADDR = 16'h8000;
            repeat (3) @(negedge Clk);
            n_checks++;
            if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
                n_fail++;
                $display("FAIL nt_idle %h got rdy=%b act=%b exp 1/0",
                         addrs[k], CPU_RDY, DMA_ACTIVE);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
            mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
        end
        test_reset();
        test_copy_even();
        test_copy_odd();
        test_page_ff();
        test_reset_abort();
        test_non_trigger();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
